// File: rtl/pio_gen2_pkg.sv
// Shared constants for the avalon_pio_gen2 PIO: register word addresses and edge-capture modes.
package pio_gen2_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_edge_sync.sv
// Two-flop pin synchroniser plus a delay flop and per-bit edge detector.
// The edge pulse is combinational from the synchronised value and its one-cycle delay.
module pio_edge_sync
  import pio_gen2_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int          EDGE_MODE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign in_sync = sync2;

  always_comb begin
    edge_pulse = sync2 & ~prev;
    case (EDGE_MODE)
      EDGE_FALL: edge_pulse = ~sync2 & prev;
      EDGE_ANY:  edge_pulse = sync2 ^ prev;
      default:   edge_pulse = sync2 & ~prev;
    endcase
  end

endmodule

// File: rtl/avalon_pio_gen2.sv
// Avalon-MM PIO slave with per-bit direction, edge capture and maskable level irq.
// Define PIO_SETCLR_EN to build the OUTSET/OUTCLEAR atomic set/clear registers.
module avalon_pio_gen2
  import pio_gen2_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_DIR = '0,
  parameter int               EDGE_MODE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic             read_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  // Bus handshake: no wait states. A read (rd) is accepted in the cycle it is
  // asserted and readdata is valid on the following cycle; a write (wr) is
  // accepted in its cycle. If both are asserted, rd returns pre-write contents.
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_pulse;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign rd           = chipselect & ~read_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  pio_edge_sync #(
    .WIDTH     (WIDTH),
    .EDGE_MODE (EDGE_MODE)
  ) u_edge_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .in_sync    (in_sync),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = (dir & data_out) | (~dir & in_sync);
      ADDR_DIR:     rd_mux[WIDTH-1:0] = dir;
      ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
      default:      rd_mux = '0;
    endcase
  end

  always_comb begin
    data_next = data_out;
    if (wr) begin
      case (address)
        ADDR_DATA:   data_next = wdata;
`ifdef PIO_SETCLR_EN
        ADDR_OUTSET: data_next = data_out | wdata;
        ADDR_OUTCLR: data_next = data_out & ~wdata;
`endif
        default:     data_next = data_out;
      endcase
    end
  end

  // A new edge in the same cycle as its write-1-clear keeps the bit set.
  assign cap_clr = (wr && address == ADDR_EDGECAP) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_OUT;
      dir      <= RESET_DIR;
      irqmask  <= '0;
      edgecap  <= '0;
      irq      <= 1'b0;
      readdata <= '0;
    end else begin
      data_out <= data_next;
      if (wr && address == ADDR_DIR)     dir     <= wdata;
      if (wr && address == ADDR_IRQMASK) irqmask <= wdata;
      edgecap <= (edgecap & ~cap_clr) | edge_pulse;
      irq     <= |(edgecap & irqmask);
      if (rd) readdata <= rd_mux;
    end
  end

  assign out_port = data_out;
  assign oe_port  = dir;

endmodule

// File: tb/tb_avalon_pio_gen2.sv
// Bench for avalon_pio_gen2: three instances (4/32/8 bits, rise/any/fall capture) on one shared bus.
// A bit-level reference model predicts each cycle's outputs; a monitor compares them one edge later.
module tb_avalon_pio_gen2;

  localparam int          NDUT       = 3;
  localparam int          W_OF[3]    = '{4, 32, 8};
  localparam int          MODE_OF[3] = '{0, 2, 1};
  localparam logic [31:0] ROUT_OF[3] = '{32'hA, 32'h0, 32'h5C};
  localparam logic [31:0] RDIR_OF[3] = '{32'hF, 32'h0, 32'h0F};

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] pins;
  logic [31:0] cur_pins;

  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic [3:0]  out_a, oe_a;
  logic [31:0] out_b, oe_b;
  logic [7:0]  out_c, oe_c;
  logic        irq_a, irq_b, irq_c;

  avalon_pio_gen2 #(.WIDTH(4), .RESET_OUT(4'hA), .RESET_DIR(4'hF), .EDGE_MODE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rdata_a),
    .in_port(pins[3:0]), .out_port(out_a), .oe_port(oe_a), .irq(irq_a)
  );

  avalon_pio_gen2 #(.WIDTH(32), .RESET_OUT(32'h0), .RESET_DIR(32'h0), .EDGE_MODE(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rdata_b),
    .in_port(pins), .out_port(out_b), .oe_port(oe_b), .irq(irq_b)
  );

  avalon_pio_gen2 #(.WIDTH(8), .RESET_OUT(8'h5C), .RESET_DIR(8'h0F), .EDGE_MODE(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(rdata_c),
    .in_port(pins[7:0]), .out_port(out_c), .oe_port(oe_c), .irq(irq_c)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard
  typedef struct {
    logic        has_rd;
    logic [31:0] rd[3];
    logic [31:0] out[3];
    logic [31:0] oe[3];
    logic        irq[3];
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: register contents and the last three sampled pin values
  logic [31:0] m_out[3];
  logic [31:0] m_dir[3];
  logic [31:0] m_msk[3];
  logic [31:0] m_cap[3];
  logic        m_irq[3];
  logic [31:0] m_pin[3][3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wmask(input int d);
    return (W_OF[d] == 32) ? 32'hFFFF_FFFF : ((32'h1 << W_OF[d]) - 32'h1);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++) begin
      m_out[d] = ROUT_OF[d];
      m_dir[d] = RDIR_OF[d];
      m_msk[d] = '0;
      m_cap[d] = '0;
      m_irq[d] = 1'b0;
      for (int k = 0; k < 3; k++) m_pin[d][k] = '0;
    end
    exp_q.delete();
  endtask

  // Driver: one bus cycle; predicts the state after the coming rising edge
  task automatic cycle(input logic cs, input logic wn, input logic rn,
                       input logic [2:0] a, input logic [31:0] wd);
    exp_t        e;
    logic        w, r;
    logic [31:0] msk, syncv, prevv, edges, rv, clr;
    @(negedge clk);
    chipselect = cs; write_n = wn; read_n = rn; address = a; writedata = wd; pins = cur_pins;
    w = cs & ~wn;
    r = cs & ~rn;
    e.has_rd = r;
    for (int d = 0; d < NDUT; d++) begin
      msk   = wmask(d);
      syncv = m_pin[d][1];
      prevv = m_pin[d][0];
      rv    = '0;
      edges = '0;
      for (int b = 0; b < W_OF[d]; b++) begin
        rv[b] = m_dir[d][b] ? m_out[d][b] : syncv[b];
        case (MODE_OF[d])
          0:       edges[b] = (syncv[b] == 1'b1) && (prevv[b] == 1'b0);
          1:       edges[b] = (syncv[b] == 1'b0) && (prevv[b] == 1'b1);
          default: edges[b] = (syncv[b] != prevv[b]);
        endcase
      end
      case (a)
        3'd0:    e.rd[d] = rv;
        3'd1:    e.rd[d] = m_dir[d];
        3'd2:    e.rd[d] = m_msk[d];
        3'd3:    e.rd[d] = m_cap[d];
        default: e.rd[d] = '0;
      endcase
      m_irq[d] = ((m_cap[d] & m_msk[d]) != 0);
      clr      = (w && a == 3'd3) ? wd : '0;
      m_cap[d] = ((m_cap[d] & ~clr) | edges) & msk;
      if (w) begin
        case (a)
          3'd0: m_out[d] = wd & msk;
          3'd1: m_dir[d] = wd & msk;
          3'd2: m_msk[d] = wd & msk;
`ifdef PIO_SETCLR_EN
          3'd4: m_out[d] = (m_out[d] | wd) & msk;
          3'd5: m_out[d] = m_out[d] & ~wd;
`endif
          default: ;
        endcase
      end
      m_pin[d][0] = m_pin[d][1];
      m_pin[d][1] = m_pin[d][2];
      m_pin[d][2] = cur_pins & msk;
      e.out[d] = m_out[d];
      e.oe[d]  = m_dir[d];
      e.irq[d] = m_irq[d];
    end
    exp_q.push_back(e);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    cycle(1'b1, 1'b0, 1'b1, a, wd);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    cycle(1'b1, 1'b1, 1'b0, a, $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 3'($urandom_range(0, 7)), $urandom);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdata_a"}, rdata_a, 32'h0);
    chk({tag, "_rdata_b"}, rdata_b, 32'h0);
    chk({tag, "_rdata_c"}, rdata_c, 32'h0);
    chk({tag, "_out_a"}, {28'h0, out_a}, ROUT_OF[0]);
    chk({tag, "_out_b"}, out_b, ROUT_OF[1]);
    chk({tag, "_out_c"}, {24'h0, out_c}, ROUT_OF[2]);
    chk({tag, "_oe_a"}, {28'h0, oe_a}, RDIR_OF[0]);
    chk({tag, "_oe_b"}, oe_b, RDIR_OF[1]);
    chk({tag, "_oe_c"}, {24'h0, oe_c}, RDIR_OF[2]);
    chk({tag, "_irq"}, {29'h0, irq_a, irq_b, irq_c}, 32'h0);
  endtask

  // Monitor: compares every post-edge state; readdata only after an accepted read
  always @(posedge clk) begin
    #1;
    if (reset_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.has_rd) begin
        chk("rdata_a", rdata_a, mon_e.rd[0]);
        chk("rdata_b", rdata_b, mon_e.rd[1]);
        chk("rdata_c", rdata_c, mon_e.rd[2]);
      end
      chk("out_a", {28'h0, out_a}, mon_e.out[0]);
      chk("out_b", out_b, mon_e.out[1]);
      chk("out_c", {24'h0, out_c}, mon_e.out[2]);
      chk("oe_a", {28'h0, oe_a}, mon_e.oe[0]);
      chk("oe_b", oe_b, mon_e.oe[1]);
      chk("oe_c", {24'h0, oe_c}, mon_e.oe[2]);
      chk("irq_a", {31'h0, irq_a}, {31'h0, mon_e.irq[0]});
      chk("irq_b", {31'h0, irq_b}, {31'h0, mon_e.irq[1]});
      chk("irq_c", {31'h0, irq_c}, {31'h0, mon_e.irq[2]});
    end
  end

  initial begin
    int   op;
    logic cs;
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; address = '0;
    writedata = '0; cur_pins = '0; pins = '0;
    model_reset();
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset values readable through DATA
    rd_reg(3'd0);

    // DATA, then atomic set and clear
    wr_reg(3'd0, 32'h3);
    wr_reg(3'd4, 32'h8);
    wr_reg(3'd5, 32'h1);
    idle(1);

    // Rising edge on bit 2 with mask, then clear
    wr_reg(3'd1, 32'h0);
    wr_reg(3'd2, 32'h4);
    cur_pins = 32'h4;
    idle(4);
    rd_reg(3'd3);
    wr_reg(3'd3, 32'h4);
    idle(2);

    // Falling edge on bit 1 lands in the same cycle as its write-1-clear
    cur_pins = 32'h2;
    idle(4);
    wr_reg(3'd3, 32'hFFFF_FFFF);
    cur_pins = 32'h0;
    idle(2);
    wr_reg(3'd3, 32'h2);
    rd_reg(3'd3);

    // Mixed direction read-back
    wr_reg(3'd1, 32'hFFFF_0000);
    wr_reg(3'd0, 32'h1234_5678);
    cur_pins = 32'h0000_ABCD;
    idle(3);
    rd_reg(3'd0);

    // Fill edgecapture on every bit, then reset in the middle of a read
    wr_reg(3'd2, 32'hFFFF_FFFF);
    cur_pins = 32'h0;
    idle(3);
    cur_pins = 32'hFFFF_FFFF;
    idle(3);
    cur_pins = 32'h0;
    idle(4);
    rd_reg(3'd3);
    rd_reg(3'd3);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    exp_q.delete();
    cur_pins = 32'hFFFF_FFFF;
    pins = cur_pins;
    repeat (2) @(posedge clk);
    #1 model_reset();
    reset_n = 1'b1;
    idle(4);
    rd_reg(3'd3);
    rd_reg(3'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      op = $urandom_range(0, 9);
      cs = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) cur_pins = cur_pins ^ $urandom;
      if (op < 4)       cycle(cs, 1'b0, 1'b1, 3'($urandom_range(0, 7)), $urandom);
      else if (op < 8)  cycle(cs, 1'b1, 1'b0, 3'($urandom_range(0, 7)), $urandom);
      else if (op == 8) cycle(cs, 1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom);
      else              cycle(cs, 1'b1, 1'b1, 3'($urandom_range(0, 7)), $urandom);
    end
    idle(2);
    @(posedge clk);
    #2 chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
